// File: rtl/dual_port_block_ram.sv
// dual_port_block_ram
// Simple dual-port synchronous RAM: port A read/write, port B read-only, one clock.
// Selectable read-during-write behaviour, 1- or 2-cycle read latency with valid
// strobes, and a clear engine that zero-fills the array one word per cycle.
//
// Ports:
//   clk                   clock, rising edge
//   reset                 asynchronous, active-low
//   clear                 pulse: start zero-fill sweep of all DEPTH words
//   busy                  high while the sweep runs; port requests ignored
//   a_en/a_we/a_addr/a_wdata   port A request (write when a_we)
//   a_rdata/a_rvalid      port A read data and 1-cycle valid strobe
//   b_en/b_addr           port B read request
//   b_rdata/b_rvalid      port B read data and 1-cycle valid strobe
module dual_port_block_ram #(
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned DATA_WIDTH     = 24,
   parameter int unsigned DEPTH          = 16,
   parameter string       INIT_MEM_FILE  = "",
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned RDW_MODE       = 0,
   parameter bit          CLEAR_ON_RESET = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   output logic                  busy,
   input  logic                  a_en,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic                  a_rvalid,
   input  logic                  b_en,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  b_rvalid
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  boot_clr;

   logic                  idle_c;
   logic                  a_acc_c;
   logic                  b_acc_c;
   logic                  a_in_c;
   logic                  b_in_c;
   logic                  a_wr_c;
   logic [DATA_WIDTH-1:0] a_rd_c;
   logic [DATA_WIDTH-1:0] b_rd_c;

   // Request qualification and read-during-write data selection
   always_comb begin
      idle_c  = (state == S_IDLE);
      a_in_c  = 32'(a_addr) < DEPTH;
      b_in_c  = 32'(b_addr) < DEPTH;
      a_acc_c = idle_c & a_en;
      b_acc_c = idle_c & b_en;
      a_wr_c  = a_acc_c & a_we & a_in_c;
      a_rd_c  = '0;
      b_rd_c  = '0;
      if (a_in_c) begin
         a_rd_c = (a_we && RDW_MODE == 1) ? a_wdata : mem[a_addr];
      end
      if (b_in_c) begin
         b_rd_c = (RDW_MODE == 1 && a_wr_c && a_addr == b_addr) ? a_wdata : mem[b_addr];
      end
   end

   // Array write port: sweep owns it while clearing, port A otherwise; never reset
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (a_wr_c) begin
         mem[a_addr] <= a_wdata;
      end
   end

   // Clear engine; boot_clr arms an automatic sweep right after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         clr_cnt  <= '0;
         busy     <= 1'b0;
         boot_clr <= CLEAR_ON_RESET;
      end else begin
         case (state)
            S_IDLE: begin
               boot_clr <= 1'b0;
               clr_cnt  <= '0;
               if (clear || boot_clr) begin
                  state <= S_CLEAR;
                  busy  <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (clr_cnt == LAST_ADDR) begin
                  state   <= S_IDLE;
                  busy    <= 1'b0;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   if (READ_LATENCY == 1) begin : g_lat1
      // Single registered read; rdata holds when nothing completes
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
         end else begin
            a_rvalid <= a_acc_c;
            b_rvalid <= b_acc_c;
            if (a_acc_c) a_rdata <= a_rd_c;
            if (b_acc_c) b_rdata <= b_rd_c;
         end
      end
   end else begin : g_lat2
      logic                  a_v1;
      logic                  b_v1;
      logic [DATA_WIDTH-1:0] a_d1;
      logic [DATA_WIDTH-1:0] b_d1;

      // Registered read plus output stage; in-flight reads drain even once busy
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            a_v1     <= 1'b0;
            b_v1     <= 1'b0;
            a_d1     <= '0;
            b_d1     <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
         end else begin
            a_v1     <= a_acc_c;
            b_v1     <= b_acc_c;
            if (a_acc_c) a_d1 <= a_rd_c;
            if (b_acc_c) b_d1 <= b_rd_c;
            a_rvalid <= a_v1;
            b_rvalid <= b_v1;
            if (a_v1) a_rdata <= a_d1;
            if (b_v1) b_rdata <= b_d1;
         end
      end
   end

endmodule

// File: tb/tb_dual_port_block_ram.sv
// Bench for dual_port_block_ram: two instances (default config, and DEPTH=12 /
// latency 2 / write-first / clear-on-reset) share one stimulus stream and are
// compared every cycle against an array-based model, plus literal spot checks.
module tb_dual_port_block_ram;

   localparam int unsigned AW = 4;
   localparam int unsigned DW = 24;
   localparam int DEP [2] = '{16, 12};
   localparam int LAT [2] = '{1, 2};
   localparam int RDW [2] = '{0, 1};
   localparam int COR [2] = '{0, 1};

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          clear = 1'b0;
   logic          a_en = 1'b0;
   logic          a_we = 1'b0;
   logic [AW-1:0] a_addr = '0;
   logic [DW-1:0] a_wdata = '0;
   logic          b_en = 1'b0;
   logic [AW-1:0] b_addr = '0;

   logic          busy_o [2];
   logic          a_rv   [2];
   logic          b_rv   [2];
   logic [DW-1:0] a_rd   [2];
   logic [DW-1:0] b_rd   [2];

   always #5 clk = ~clk;

   dual_port_block_ram #(
      .ADDR_WIDTH(4), .DATA_WIDTH(24), .DEPTH(16), .INIT_MEM_FILE(""),
      .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1'b0)
   ) dut0 (
      .clk(clk), .reset(reset), .clear(clear), .busy(busy_o[0]),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rd[0]), .a_rvalid(a_rv[0]),
      .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rd[0]), .b_rvalid(b_rv[0])
   );

   dual_port_block_ram #(
      .ADDR_WIDTH(4), .DATA_WIDTH(24), .DEPTH(12), .INIT_MEM_FILE(""),
      .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1'b1)
   ) dut1 (
      .clk(clk), .reset(reset), .clear(clear), .busy(busy_o[1]),
      .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rd[1]), .a_rvalid(a_rv[1]),
      .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rd[1]), .b_rvalid(b_rv[1])
   );

   // Model state: memory image, remaining sweep words, and delivery slots
   // indexed by the edge number at which a read becomes visible.
   logic [DW-1:0] mm   [2][16];
   int            clr_left [2];
   bit            boot [2];
   bit            busy_e [2];
   bit            sv   [2][2][4];
   logic [DW-1:0] sd   [2][2][4];
   logic [DW-1:0] hold [2][2];
   int            ecnt = 0;
   int            errors = 0;
   int            checks = 0;
   int            n0;
   int            n1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         clr_left[d] = 0;
         boot[d]     = (COR[d] == 1);
         busy_e[d]   = 1'b0;
         for (int p = 0; p < 2; p++) begin
            hold[d][p] = '0;
            for (int s = 0; s < 4; s++) sv[d][p][s] = 1'b0;
         end
      end
   endtask

   task automatic model_edge();
      int slot;
      bit ain;
      bit bin;
      for (int d = 0; d < 2; d++) begin
         if (clr_left[d] == 0) begin
            slot = (ecnt + LAT[d] - 1) % 4;
            ain  = int'(a_addr) < DEP[d];
            bin  = int'(b_addr) < DEP[d];
            if (a_en) begin
               sv[d][0][slot] = 1'b1;
               sd[d][0][slot] = !ain ? '0 : (a_we && RDW[d] == 1) ? a_wdata : mm[d][a_addr];
            end
            if (b_en) begin
               sv[d][1][slot] = 1'b1;
               sd[d][1][slot] = !bin ? '0 :
                  (RDW[d] == 1 && a_en && a_we && ain && a_addr == b_addr) ? a_wdata : mm[d][b_addr];
            end
            if (a_en && a_we && ain) mm[d][a_addr] = a_wdata;
            if (clear || boot[d]) clr_left[d] = DEP[d];
            boot[d] = 1'b0;
         end else begin
            mm[d][DEP[d] - clr_left[d]] = '0;
            clr_left[d]--;
         end
         busy_e[d] = (clr_left[d] != 0);
      end
   endtask

   task automatic compare();
      int s;
      bit ev;
      s = ecnt % 4;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d busy", d), 32'(busy_o[d]), 32'(busy_e[d]));
         for (int p = 0; p < 2; p++) begin
            ev = sv[d][p][s];
            if (ev) hold[d][p] = sd[d][p][s];
            sv[d][p][s] = 1'b0;
            check($sformatf("d%0d %s rvalid", d, p == 0 ? "a" : "b"),
                  32'(p == 0 ? a_rv[d] : b_rv[d]), 32'(ev));
            check($sformatf("d%0d %s rdata", d, p == 0 ? "a" : "b"),
                  32'(p == 0 ? a_rd[d] : b_rd[d]), 32'(hold[d][p]));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) begin
         ecnt++;
         model_edge();
      end
      @(negedge clk);
      compare();
   endtask

   task automatic drive(input bit c, input bit ae, input bit aw, input int aa, input int wd,
                        input bit be, input int ba);
      clear   = c;
      a_en    = ae;
      a_we    = aw;
      a_addr  = AW'(aa);
      a_wdata = DW'(wd);
      b_en    = be;
      b_addr  = AW'(ba);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Reset asserted between edges; outputs must drop without waiting for a clock
   task automatic hit_reset();
      #2 reset = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("async rst d%0d busy", d), 32'(busy_o[d]), 32'd0);
         check($sformatf("async rst d%0d a_rvalid", d), 32'(a_rv[d]), 32'd0);
         check($sformatf("async rst d%0d b_rvalid", d), 32'(b_rv[d]), 32'd0);
         check($sformatf("async rst d%0d a_rdata", d), 32'(a_rd[d]), 32'd0);
         check($sformatf("async rst d%0d b_rdata", d), 32'(b_rd[d]), 32'd0);
      end
      @(negedge clk);
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      idle();
      step();
      step();
      reset = 1'b1;

      // Establish known contents in both arrays
      drive(1, 0, 0, 0, 0, 0, 0);
      step();
      idle();
      repeat (20) step();

      // Write then read back address 3
      drive(0, 1, 1, 3, 'h123456, 0, 0);
      step();
      check("t1 d0 write returns old", 32'(a_rd[0]), 32'h0);
      drive(0, 1, 0, 3, 0, 0, 0);
      step();
      check("t1 d0 read data", 32'(a_rd[0]), 32'h123456);
      check("t1 d0 read valid", 32'(a_rv[0]), 32'd1);
      idle();
      step();
      check("t1 d0 strobe drops", 32'(a_rv[0]), 32'd0);
      check("t1 d0 data holds", 32'(a_rd[0]), 32'h123456);
      check("t1 d1 read data", 32'(a_rd[1]), 32'h123456);

      // Back-to-back B reads of 3,4,5
      drive(0, 1, 1, 4, 'hABCDEF, 0, 0);
      step();
      drive(0, 1, 1, 5, 'h13579B, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 1, 3);
      step();
      drive(0, 0, 0, 0, 0, 1, 4);
      step();
      check("t2 d1 b first", 32'(b_rd[1]), 32'h123456);
      drive(0, 0, 0, 0, 0, 1, 5);
      step();
      check("t2 d1 b second", 32'(b_rd[1]), 32'hABCDEF);
      idle();
      step();
      check("t2 d1 b third", 32'(b_rd[1]), 32'h13579B);
      check("t2 d1 b third valid", 32'(b_rv[1]), 32'd1);
      step();
      check("t2 d1 b done", 32'(b_rv[1]), 32'd0);

      // Same-address collision at 7
      drive(0, 1, 1, 7, 'hAAAAAA, 0, 0);
      step();
      drive(0, 1, 1, 7, 'h555555, 1, 7);
      step();
      check("t3 d0 b old word", 32'(b_rd[0]), 32'hAAAAAA);
      idle();
      step();
      check("t3 d1 b new word", 32'(b_rd[1]), 32'h555555);
      check("t3 d1 a new word", 32'(a_rd[1]), 32'h555555);

      // Fill, then sweep with port traffic held on during busy
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 1, i, 'hFFFFFF, 0, 0);
         step();
      end
      drive(1, 1, 0, 0, 0, 0, 0);
      step();
      check("t4 d0 access with clear", 32'(a_rd[0]), 32'hFFFFFF);
      n0 = int'(busy_o[0]);
      n1 = int'(busy_o[1]);
      drive(0, 1, 0, 2, 0, 1, 9);
      for (int i = 0; i < 20; i++) begin
         step();
         n0 += int'(busy_o[0]);
         n1 += int'(busy_o[1]);
      end
      check("t4 d0 busy cycles", 32'(n0), 32'd16);
      check("t4 d1 busy cycles", 32'(n1), 32'd12);
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0, i, 0, 1, 15 - i);
         step();
      end
      idle();
      step();
      step();
      check("t4 d0 last read zero", 32'(a_rd[0]), 32'h0);
      check("t4 d0 b last read zero", 32'(b_rd[0]), 32'h0);

      // Out-of-range on the DEPTH=12 instance
      drive(0, 1, 1, 1, 'h000111, 0, 0);
      step();
      drive(0, 1, 1, 13, 'hBADBAD, 0, 0);
      step();
      drive(0, 1, 0, 13, 0, 0, 0);
      step();
      idle();
      step();
      check("t5 d1 oor valid", 32'(a_rv[1]), 32'd1);
      check("t5 d1 oor data", 32'(a_rd[1]), 32'h0);
      check("t5 d0 in-range 13", 32'(a_rd[0]), 32'hBADBAD);
      drive(0, 1, 0, 1, 0, 0, 0);
      step();
      idle();
      step();
      check("t5 d1 no wrap", 32'(a_rd[1]), 32'h000111);

      // Reset mid-sweep after words 0..4 cleared
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 1, i, 'hFFFFFF, 0, 0);
         step();
      end
      drive(1, 0, 0, 0, 0, 0, 0);
      step();
      idle();
      repeat (5) step();
      hit_reset();
      drive(0, 1, 0, 4, 0, 0, 0);
      step();
      check("t6 d0 word4 cleared", 32'(a_rd[0]), 32'h0);
      drive(0, 1, 0, 5, 0, 0, 0);
      step();
      check("t6 d0 word5 kept", 32'(a_rd[0]), 32'hFFFFFF);
      drive(0, 1, 0, 6, 0, 0, 0);
      step();
      check("t6 d0 word6 kept", 32'(a_rd[0]), 32'hFFFFFF);
      idle();
      repeat (14) step();
      for (int i = 0; i < 16; i++) begin
         drive(0, 1, 0, i, 0, 1, i);
         step();
      end
      idle();
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
